// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } refill_state_t;

    function automatic int calc_offset_w(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int calc_index_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int num_lines, input int line_bytes);
        return addr_w - $clog2(num_lines) - $clog2(line_bytes);
    endfunction

    function automatic int calc_words_per_line(input int line_bytes);
        return line_bytes / 4;
    endfunction

    // A one-word line still needs a 1-bit counter so the port never collapses to zero width.
    function automatic int calc_beat_cnt_w(input int line_bytes);
        return (line_bytes > 4) ? $clog2(line_bytes / 4) : 1;
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill controller: latches the miss address, runs the request/beat handshake
// and tells the cache arrays when to write a word and when to install a line.
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int NUM_LINES  = 16,
    parameter int LINE_BYTES = 16,
    localparam int OFFSET_W  = calc_offset_w(LINE_BYTES),
    localparam int WORDS     = calc_words_per_line(LINE_BYTES),
    localparam int BCW       = calc_beat_cnt_w(LINE_BYTES)
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PC,
    input  logic              pc_valid,
    input  logic              miss,
    input  logic              flush,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    output refill_state_t     state,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BCW-1:0]    beat_cnt,
    output logic              word_we,
    output logic              line_we,
    output logic              miss_start
);

    refill_state_t     state_reg, state_next;
    logic [BCW-1:0]    beat_cnt_reg, beat_cnt_next;
    logic [ADDR_W-1:0] miss_addr_reg, miss_addr_next;
    logic              flush_pending_reg, flush_pending_next;
    logic              unused_offset_bits;

    assign unused_offset_bits = ^PC[OFFSET_W-1:0];

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_reg         <= IDLE;
            beat_cnt_reg      <= '0;
            miss_addr_reg     <= '0;
            flush_pending_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            beat_cnt_reg      <= beat_cnt_next;
            miss_addr_reg     <= miss_addr_next;
            flush_pending_reg <= flush_pending_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        beat_cnt_next      = beat_cnt_reg;
        miss_addr_next     = miss_addr_reg;
        flush_pending_next = flush_pending_reg;
        mem_req            = 1'b0;
        word_we            = 1'b0;
        line_we            = 1'b0;
        miss_start         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pc_valid && miss && !flush) begin
                    miss_start     = 1'b1;
                    miss_addr_next = {PC[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                    state_next     = REQ;
                end
            end
            REQ: begin
                mem_req = 1'b1;
                if (flush) flush_pending_next = 1'b1;
                if (mem_ack) state_next = FILL;
            end
            FILL: begin
                if (flush) flush_pending_next = 1'b1;
                if (mem_rvalid) begin
                    word_we = 1'b1;
                    if (beat_cnt_reg == BCW'(WORDS - 1)) begin
                        beat_cnt_next = '0;
                        state_next    = DONE;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + BCW'(1);
                    end
                end
            end
            DONE: begin
                // A flush arriving in this very cycle must also keep the stale line out.
                line_we            = !flush_pending_reg && !flush;
                flush_pending_next = 1'b0;
                state_next         = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign state    = state_reg;
    assign mem_addr = miss_addr_reg;
    assign beat_cnt = beat_cnt_reg;

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with combinational hit path and line refill.
// Optional hit/miss counters are built when ICACHE_PERF_CNT_EN is defined.
module icache_dm
    import icache_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int NUM_LINES  = 16,
    parameter int LINE_BYTES = 16,
    parameter int BEAT_W     = 32
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] PC,
    input  logic              pc_valid,
    input  logic              flush,
    output logic              icache_r,
    output logic [31:0]       instruction,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic              mem_rvalid,
    input  logic [BEAT_W-1:0] mem_rdata,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
);

    localparam int OFFSET_W = calc_offset_w(LINE_BYTES);
    localparam int INDEX_W  = calc_index_w(NUM_LINES);
    localparam int TAG_W    = calc_tag_w(ADDR_W, NUM_LINES, LINE_BYTES);
    localparam int WORDS    = calc_words_per_line(LINE_BYTES);
    localparam int BCW      = calc_beat_cnt_w(LINE_BYTES);
    localparam int DATA_AW  = INDEX_W + OFFSET_W - 2;

    logic               valid_reg [NUM_LINES];
    logic [TAG_W-1:0]   tag_mem   [NUM_LINES];
    logic [31:0]        data_mem  [NUM_LINES*WORDS];

    refill_state_t      state;
    logic [BCW-1:0]     beat_cnt;
    logic               word_we, line_we, miss_start, tag_hit;
    logic [INDEX_W-1:0] pc_index, fill_index;
    logic [TAG_W-1:0]   pc_tag, fill_tag;
    logic [DATA_AW-1:0] data_waddr;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^{PC[1:0], mem_addr[1:0]};

    assign pc_index   = PC[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign pc_tag     = PC[ADDR_W-1:INDEX_W+OFFSET_W];
    assign fill_index = mem_addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign fill_tag   = mem_addr[ADDR_W-1:INDEX_W+OFFSET_W];
    // Miss address has zero word bits, so OR-ing the beat counter selects the word.
    assign data_waddr = mem_addr[DATA_AW+1:2] | DATA_AW'(beat_cnt);

    assign tag_hit     = valid_reg[pc_index] && (tag_mem[pc_index] == pc_tag);
    assign icache_r    = pc_valid && tag_hit && (state == IDLE) && !flush;
    assign instruction = data_mem[PC[DATA_AW+1:2]];

    icache_refill_fsm #(
        .ADDR_W     (ADDR_W),
        .NUM_LINES  (NUM_LINES),
        .LINE_BYTES (LINE_BYTES)
    ) u_fsm (
        .CLK        (CLK),
        .reset      (reset),
        .PC         (PC),
        .pc_valid   (pc_valid),
        .miss       (!tag_hit),
        .flush      (flush),
        .mem_ack    (mem_ack),
        .mem_rvalid (mem_rvalid),
        .state      (state),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .beat_cnt   (beat_cnt),
        .word_we    (word_we),
        .line_we    (line_we),
        .miss_start (miss_start)
    );

    // Flush invalidates every line whatever the refill state; installs come from DONE only.
    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
            always_ff @(posedge CLK or negedge reset) begin
                if (!reset) begin
                    valid_reg[gi] <= 1'b0;
                end else if (flush) begin
                    valid_reg[gi] <= 1'b0;
                end else if (line_we && (fill_index == INDEX_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (line_we) tag_mem[fill_index] <= fill_tag;
    end

    always_ff @(posedge CLK) begin
        if (word_we) data_mem[data_waddr] <= mem_rdata[31:0];
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] perf_hits_reg, perf_misses_reg;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            perf_hits_reg   <= '0;
            perf_misses_reg <= '0;
        end else begin
            if (icache_r)   perf_hits_reg   <= perf_hits_reg + 32'd1;
            if (miss_start) perf_misses_reg <= perf_misses_reg + 32'd1;
        end
    end

    assign perf_hits   = perf_hits_reg;
    assign perf_misses = perf_misses_reg;
`else
    logic unused_miss_start;
    assign unused_miss_start = miss_start;
    assign perf_hits         = 32'd0;
    assign perf_misses       = 32'd0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Randomised scoreboard bench for icache_dm against a memory-image cache model.
module tb_icache_dm;

    localparam int WORDS = 4;
`ifdef ICACHE_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        CLK, reset;
    logic [63:0] PC;
    logic        pc_valid, flush;
    logic        icache_r;
    logic [31:0] instruction;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack, mem_rvalid;
    logic [31:0] mem_rdata;
    logic [31:0] perf_hits, perf_misses;

    icache_dm dut (
        .CLK         (CLK),
        .reset       (reset),
        .PC          (PC),
        .pc_valid    (pc_valid),
        .flush       (flush),
        .icache_r    (icache_r),
        .instruction (instruction),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .perf_hits   (perf_hits),
        .perf_misses (perf_misses)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    // Reference model: which memory line each cache slot holds.
    bit          m_valid [16];
    logic [55:0] m_tag   [16];
    int          exp_hits, exp_misses;

    // Bus model state
    int          ack_delay_cfg = 0;
    int          gap_cfg = 0;
    int          req_count = 0;
    int          beat_idx = 0;
    int          bus_phase = 0;
    logic [63:0] exp_line_addr = '0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h40:  return 32'h0050_0093;
            64'h44:  return 32'hFFDF_F06F;
            64'h48:  return 32'h0;
            64'h4C:  return 32'h0;
            default: return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1234_5678;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    endtask

    // Memory bus responder with programmable ack latency and beat gaps.
    logic [63:0] req_addr;
    int          delay_left, gap_left;
    initial begin
        mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge CLK); #1;
            mem_ack = 1'b0; mem_rvalid = 1'b0;
            if (!reset) begin
                bus_phase = 0;
            end else begin
                case (bus_phase)
                    0: begin
                        // junk beats outside a refill must be ignored
                        mem_rvalid = 1'($urandom_range(0, 1));
                        mem_rdata  = $urandom;
                        if (mem_req) begin
                            req_count++;
                            req_addr   = mem_addr;
                            delay_left = ack_delay_cfg;
                            beat_idx   = 0;
                            bus_phase  = 1;
                            chk("req_addr", mem_addr, exp_line_addr);
                        end
                    end
                    2: begin
                        if (gap_left > 0) begin
                            gap_left--;
                        end else begin
                            mem_rvalid = 1'b1;
                            mem_rdata  = mem_word(req_addr + 64'(4 * beat_idx));
                            beat_idx++;
                            gap_left = gap_cfg;
                            if (beat_idx == WORDS) bus_phase = 0;
                        end
                    end
                    default: ;
                endcase
                if (bus_phase == 1) begin
                    chk("req_held", {63'd0, mem_req}, 64'd1);
                    chk("req_addr_stable", mem_addr, req_addr);
                    chk("no_hit_in_req", {63'd0, icache_r}, 64'd0);
                    if (delay_left > 0) begin
                        delay_left--;
                    end else begin
                        mem_ack   = 1'b1;
                        gap_left  = 0;
                        bus_phase = 2;
                    end
                end
            end
        end
    end

    // Monitor: every hit cycle must match the next queued expectation.
    always @(negedge CLK) begin
        if (reset && icache_r) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_hit: got hit at pc %0h expected no hit", PC);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("hit_pc", PC, e.pc);
                chk("hit_instr", {32'd0, instruction}, {32'd0, e.data});
            end
        end
    end

    task automatic fetch(input logic [63:0] addr, input int hold);
        bit          exp_hit, first_hit;
        int          req0, cyc;
        logic [3:0]  idx;
        logic [55:0] tag;
        exp_t        e;
        idx = addr[7:4];
        tag = addr[63:8];
        exp_hit = m_valid[idx] && (m_tag[idx] == tag);
        e.pc = addr; e.data = mem_word({addr[63:2], 2'b00});
        for (int k = 0; k < hold; k++) exp_q.push_back(e);
        exp_line_addr = {addr[63:4], 4'h0};
        req0 = req_count;
        @(posedge CLK); #1;
        PC = addr; pc_valid = 1'b1;
        @(negedge CLK);
        first_hit = icache_r;
        cyc = 0;
        while (!icache_r && cyc < 300) begin
            @(negedge CLK);
            cyc++;
        end
        if (!icache_r) begin
            checks++; errors++;
            $display("FAIL fetch_timeout: got no hit for pc %0h expected hit within 300 cycles", addr);
        end
        chk("first_cycle_hit", {63'd0, first_hit}, {63'd0, exp_hit});
        if (!exp_hit) chk("miss_latency_ok", {63'd0, cyc >= 3 + WORDS}, 64'd1);
        for (int k = 1; k < hold; k++) begin
            @(negedge CLK);
            chk("hit_held", {63'd0, icache_r}, 64'd1);
        end
        @(posedge CLK); #1;
        pc_valid = 1'b0;
        chk("refill_count", 64'(req_count - req0), exp_hit ? 64'd0 : 64'd1);
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        exp_hits += hold;
        if (!exp_hit) exp_misses++;
    endtask

    task automatic wait_bus_idle();
        int n = 0;
        while (bus_phase != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("bus_idle", 64'(bus_phase), 64'd0);
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        int n, req0;
        reset = 1'b0; PC = '0; pc_valid = 1'b0; flush = 1'b0;
        model_clear();
        exp_hits = 0; exp_misses = 0;
        repeat (3) @(negedge CLK);
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_icache_r", {63'd0, icache_r}, 64'd0);
        chk("rst_perf_hits", {32'd0, perf_hits}, 64'd0);
        chk("rst_perf_misses", {32'd0, perf_misses}, 64'd0);
        #2 reset = 1'b1;

        // Cold miss then a ten-cycle hit run
        fetch(64'h40, 10);
        chk("perf_misses_1", {32'd0, perf_misses}, PERF_EN ? 64'd1 : 64'd0);
        chk("perf_hits_10", {32'd0, perf_hits}, PERF_EN ? 64'd10 : 64'd0);
        fetch(64'h44, 1);

        // Conflict eviction on index 4
        fetch(64'h140, 1);
        fetch(64'h40, 1);

        // Stalled bus
        ack_delay_cfg = 5; gap_cfg = 2;
        fetch(64'h388, 1);
        fetch(64'h38C, 2);
        ack_delay_cfg = 0; gap_cfg = 1;

        // Flush in the middle of a refill
        exp_line_addr = 64'h2A0;
        @(posedge CLK); #1;
        PC = 64'h2A0; pc_valid = 1'b1;
        n = 0;
        while (!mem_req && n < 50) begin @(negedge CLK); n++; end
        chk("flush_test_req", {63'd0, mem_req}, 64'd1);
        @(posedge CLK); #1;
        pc_valid = 1'b0; PC = 64'h777;
        n = 0;
        while (beat_idx < 2 && n < 50) begin @(negedge CLK); n++; end
        @(posedge CLK); #1 flush = 1'b1;
        @(posedge CLK); #1 flush = 1'b0;
        wait_bus_idle();
        m_valid[10] = 1'b0;
        fetch(64'h2A4, 1);

        // Flush in IDLE: forces icache_r low and wins over a miss
        req0 = req_count;
        @(posedge CLK); #1;
        PC = 64'h40; pc_valid = 1'b1; flush = 1'b1;
        @(negedge CLK);
        chk("flush_blocks_hit", {63'd0, icache_r}, 64'd0);
        @(negedge CLK);
        chk("flush_blocks_hit2", {63'd0, icache_r}, 64'd0);
        @(posedge CLK); #1;
        flush = 1'b0; pc_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("flush_no_refill", 64'(req_count - req0), 64'd0);
        model_clear();
        fetch(64'h40, 1);

        // Randomised fetch stream over a small address pool
        for (int t = 0; t < 60; t++) begin
            logic [63:0] a;
            a = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_0000_0000 : 64'h0;
            a = a | (64'($urandom_range(0, 3)) << 8) | (64'($urandom_range(0, 15)) << 4)
                  | (64'($urandom_range(0, 3)) << 2);
            ack_delay_cfg = $urandom_range(0, 3);
            gap_cfg       = $urandom_range(0, 2);
            fetch(a, $urandom_range(1, 3));
        end

        // Asynchronous reset mid-refill
        ack_delay_cfg = 0; gap_cfg = 1;
        exp_line_addr = 64'h500;
        @(posedge CLK); #1;
        PC = 64'h500; pc_valid = 1'b1;
        n = 0;
        while (beat_idx < 2 && n < 50) begin @(negedge CLK); n++; end
        chk("reset_test_fill", 64'(beat_idx >= 2), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("async_rst_icache_r", {63'd0, icache_r}, 64'd0);
        chk("async_rst_state", {62'd0, dut.u_fsm.state_reg}, {62'd0, icache_pkg::IDLE});
        chk("async_rst_perf", {32'd0, perf_hits}, 64'd0);
        pc_valid = 1'b0;
        repeat (2) @(negedge CLK);
        #2 reset = 1'b1;
        model_clear();
        exp_hits = 0; exp_misses = 0;
        fetch(64'h44, 1);

        repeat (2) @(negedge CLK);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        chk("perf_hits_final", {32'd0, perf_hits}, PERF_EN ? 64'(exp_hits) : 64'd0);
        chk("perf_misses_final", {32'd0, perf_misses}, PERF_EN ? 64'(exp_misses) : 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end

endmodule
